bht_write_ctrl: RTL and testbench

BHT_WRITE_CTRL -- requirements
Module: bht_write_ctrl

---
 rtl/bht_write_ctrl.sv | 114 +++++++++++
 tb/tb_bht_write_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bht_write_ctrl.sv
// Single write port of the branch history table: clears the table after
// reset/invalidate, then arbitrates counter updates against queued allocations.
module bht_write_ctrl (
    input  logic        CLK,
    input  logic        nrst,
    input  logic        inv_all,
    input  logic        alloc_valid,
    input  logic [3:0]  alloc_set,
    input  logic [5:0]  alloc_tag,
    input  logic [9:0]  alloc_target,
    input  logic        alloc_jump,
    output logic        alloc_ready,
    input  logic        upd_valid,
    input  logic [3:0]  upd_set,
    input  logic [1:0]  upd_way,
    input  logic [18:0] upd_entry,
    input  logic        upd_taken,
    output logic        ht_we,
    output logic [5:0]  ht_waddr,
    output logic [18:0] ht_wdata,
    output logic        init_busy
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    typedef struct packed {
        logic [3:0] set;
        logic [5:0] tag;
        logic [9:0] target;
        logic       jump;
    } alloc_req_t;

    state_t                 state;
    logic [5:0]             init_idx;
    alloc_req_t [1:0]       fifo_q;
    logic [1:0]             count;
    logic [15:0][1:0]       ptr;

    alloc_req_t             req;
    alloc_req_t             head;
    logic                   upd_go;
    logic                   push;
    logic                   pop;
    logic [1:0]             push_slot;
    logic [1:0]             ctr_nxt;

    assign alloc_ready = (state == S_RUN) && (count != 2'd2);
    assign init_busy   = (state == S_INIT);

    assign req       = '{set: alloc_set, tag: alloc_tag, target: alloc_target, jump: alloc_jump};
    assign head      = fifo_q[0];
    assign upd_go    = upd_valid && upd_entry[18];
    assign push      = alloc_valid && alloc_ready;
    assign pop       = (state == S_RUN) && !upd_go && (count != 2'd0);
    // A simultaneous pop frees slot 0 before the new entry lands.
    assign push_slot = count - {1'b0, pop};

    always_comb begin
        ctr_nxt = upd_entry[1:0];
        if (upd_taken) begin
            if (upd_entry[1:0] != 2'b11) ctr_nxt = upd_entry[1:0] + 2'd1;
        end else begin
            if (upd_entry[1:0] != 2'b00) ctr_nxt = upd_entry[1:0] - 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state    <= S_INIT;
            init_idx <= '0;
            fifo_q   <= '0;
            count    <= '0;
            ptr      <= '0;
            ht_we    <= 1'b0;
            ht_waddr <= '0;
            ht_wdata <= '0;
        end else if (inv_all) begin
            state    <= S_INIT;
            init_idx <= '0;
            count    <= '0;
            ptr      <= '0;
            ht_we    <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    ht_we    <= 1'b1;
                    ht_waddr <= init_idx;
                    ht_wdata <= '0;
                    init_idx <= init_idx + 6'd1;
                    if (init_idx == 6'd63) state <= S_RUN;
                end
                S_RUN: begin
                    ht_we <= 1'b0;
                    if (upd_go) begin
                        ht_we    <= 1'b1;
                        ht_waddr <= {upd_set, upd_way};
                        ht_wdata <= {upd_entry[18:2], ctr_nxt};
                    end else if (pop) begin
                        ht_we          <= 1'b1;
                        ht_waddr       <= {head.set, ptr[head.set]};
                        ht_wdata       <= {1'b1, head.tag, head.target,
                                           head.jump ? 2'b11 : 2'b01};
                        ptr[head.set]  <= ptr[head.set] + 2'd1;
                    end
                    if (pop)  fifo_q[0]            <= fifo_q[1];
                    if (push) fifo_q[push_slot[0]] <= req;
                    count <= count + {1'b0, push} - {1'b0, pop};
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_bht_write_ctrl.sv
// Scoreboard bench for bht_write_ctrl: expected table writes are queued at
// stimulus time and matched in order against every observed ht_we pulse.
module tb_bht_write_ctrl;

    logic        CLK = 1'b0;
    logic        nrst;
    logic        inv_all;
    logic        alloc_valid;
    logic [3:0]  alloc_set;
    logic [5:0]  alloc_tag;
    logic [9:0]  alloc_target;
    logic        alloc_jump;
    logic        alloc_ready;
    logic        upd_valid;
    logic [3:0]  upd_set;
    logic [1:0]  upd_way;
    logic [18:0] upd_entry;
    logic        upd_taken;
    logic        ht_we;
    logic [5:0]  ht_waddr;
    logic [18:0] ht_wdata;
    logic        init_busy;

    int total = 0;
    int bad   = 0;
    logic [24:0] exp_q[$];

    bht_write_ctrl dut (
        .CLK(CLK), .nrst(nrst), .inv_all(inv_all),
        .alloc_valid(alloc_valid), .alloc_set(alloc_set), .alloc_tag(alloc_tag),
        .alloc_target(alloc_target), .alloc_jump(alloc_jump), .alloc_ready(alloc_ready),
        .upd_valid(upd_valid), .upd_set(upd_set), .upd_way(upd_way),
        .upd_entry(upd_entry), .upd_taken(upd_taken),
        .ht_we(ht_we), .ht_waddr(ht_waddr), .ht_wdata(ht_wdata), .init_busy(init_busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (nrst && ht_we) begin
            if (exp_q.size() == 0) chk("extra_wr", 32'(ht_we), 32'd0);
            else chk("wr", 32'({ht_waddr, ht_wdata}), 32'(exp_q.pop_front()));
        end
    end

    task automatic idle();
        inv_all     = 1'b0;
        alloc_valid = 1'b0;
        upd_valid   = 1'b0;
    endtask

    task automatic drv_alloc(input logic [3:0] s, input logic [5:0] t,
                             input logic [9:0] tgt, input logic j);
        alloc_valid  = 1'b1;
        alloc_set    = s;
        alloc_tag    = t;
        alloc_target = tgt;
        alloc_jump   = j;
    endtask

    task automatic drv_upd(input logic [3:0] s, input logic [1:0] w,
                           input logic [18:0] e, input logic tk);
        upd_valid = 1'b1;
        upd_set   = s;
        upd_way   = w;
        upd_entry = e;
        upd_taken = tk;
    endtask

    task automatic push_clears();
        for (int i = 0; i < 64; i++) exp_q.push_back({6'(i), 19'd0});
    endtask

    task automatic drain(input int lim, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(negedge CLK); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [5:0] tg;
        logic [9:0] tgt;
        logic       jp;
        logic [1:0] ctr_tab  [5] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd2};
        logic       tk_tab   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [1:0] exp_tab  [5] = '{2'd3, 2'd0, 2'd2, 2'd3, 2'd1};
        logic       v_tab    [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        nrst = 1'b0;
        idle();
        alloc_set = '0; alloc_tag = '0; alloc_target = '0; alloc_jump = 1'b0;
        upd_set = '0; upd_way = '0; upd_entry = '0; upd_taken = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_we",    32'(ht_we), 32'd0);
        chk("rst_busy",  32'(init_busy), 32'd1);
        chk("rst_rdy",   32'(alloc_ready), 32'd0);
        chk("rst_waddr", 32'(ht_waddr), 32'd0);
        chk("rst_wdata", 32'(ht_wdata), 32'd0);

        // power-up clear
        push_clears();
        nrst = 1'b1;
        #1;
        drain(200, n);
        chk("init_len", 32'(n), 32'd64);
        @(negedge CLK);
        chk("run_busy", 32'(init_busy), 32'd0);
        chk("run_rdy",  32'(alloc_ready), 32'd1);

        // five allocations to set 5: ways 0..3 then wrap to 0
        for (int t = 1; t <= 5; t++) begin
            @(negedge CLK);
            if (t == 2) chk("lat_edge1", 32'(ht_we), 32'd0);
            if (t == 3) chk("lat_edge2", 32'(ht_we), 32'd1);
            tg  = (t == 5) ? 6'd9 : 6'(t);
            tgt = 10'h100 + 10'(t);
            jp  = (t == 2);
            drv_alloc(4'd5, tg, tgt, jp);
            exp_q.push_back({4'd5, 2'((t - 1) % 4), 1'b1, tg, tgt, jp ? 2'b11 : 2'b01});
        end
        @(negedge CLK);
        idle();
        drain(20, n);

        // counter updates, one with the valid bit clear
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            drv_upd(4'd3, 2'(i), {v_tab[i], 6'd7, 10'h55 + 10'(i), ctr_tab[i]}, tk_tab[i]);
            if (v_tab[i])
                exp_q.push_back({4'd3, 2'(i), 1'b1, 6'd7, 10'h55 + 10'(i), exp_tab[i]});
        end
        @(negedge CLK);
        idle();
        drain(20, n);

        // updates win over the FIFO; two allocations back up, then drain in order
        @(negedge CLK);
        drv_upd(4'd2, 2'd0, {1'b1, 6'd11, 10'h3a0, 2'd1}, 1'b1);
        drv_alloc(4'd5, 6'd20, 10'h2a0, 1'b0);
        exp_q.push_back({4'd2, 2'd0, 1'b1, 6'd11, 10'h3a0, 2'd2});
        @(negedge CLK);
        chk("rdy_one", 32'(alloc_ready), 32'd1);
        drv_upd(4'd2, 2'd1, {1'b1, 6'd12, 10'h3a1, 2'd2}, 1'b0);
        drv_alloc(4'd5, 6'd21, 10'h2a1, 1'b1);
        exp_q.push_back({4'd2, 2'd1, 1'b1, 6'd12, 10'h3a1, 2'd1});
        @(negedge CLK);
        idle();
        chk("rdy_full", 32'(alloc_ready), 32'd0);
        exp_q.push_back({4'd5, 2'd1, 1'b1, 6'd20, 10'h2a0, 2'b01});
        exp_q.push_back({4'd5, 2'd2, 1'b1, 6'd21, 10'h2a1, 2'b11});
        drain(20, n);

        // invalidate with two pending allocations and a colliding update
        @(negedge CLK);
        drv_upd(4'd9, 2'd3, {1'b1, 6'd1, 10'h001, 2'd0}, 1'b1);
        drv_alloc(4'd5, 6'd30, 10'h111, 1'b0);
        exp_q.push_back({4'd9, 2'd3, 1'b1, 6'd1, 10'h001, 2'd1});
        @(negedge CLK);
        drv_upd(4'd9, 2'd2, {1'b1, 6'd2, 10'h002, 2'd3}, 1'b0);
        drv_alloc(4'd6, 6'd31, 10'h222, 1'b1);
        exp_q.push_back({4'd9, 2'd2, 1'b1, 6'd2, 10'h002, 2'd2});
        @(negedge CLK);
        inv_all = 1'b1;
        alloc_valid = 1'b0;
        drv_upd(4'd8, 2'd0, {1'b1, 6'd3, 10'h003, 2'd1}, 1'b1);
        @(negedge CLK);
        idle();
        chk("inv_busy", 32'(init_busy), 32'd1);
        chk("inv_we",   32'(ht_we), 32'd0);
        chk("inv_q",    32'(exp_q.size()), 32'd0);
        push_clears();
        #1;
        drain(200, n);
        chk("reinit_len", 32'(n), 32'd64);
        @(negedge CLK);
        drv_alloc(4'd5, 6'h3f, 10'h3ff, 1'b1);
        exp_q.push_back({4'd5, 2'd0, 1'b1, 6'h3f, 10'h3ff, 2'b11});
        @(negedge CLK);
        idle();
        drain(20, n);

        // asynchronous reset with an allocation still queued
        @(negedge CLK);
        drv_upd(4'd1, 2'd1, {1'b1, 6'd4, 10'h004, 2'd2}, 1'b1);
        drv_alloc(4'd7, 6'd5, 10'h005, 1'b0);
        exp_q.push_back({4'd1, 2'd1, 1'b1, 6'd4, 10'h004, 2'd3});
        @(negedge CLK);
        idle();
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_we",   32'(ht_we), 32'd0);
        chk("arst_busy", 32'(init_busy), 32'd1);
        chk("arst_rdy",  32'(alloc_ready), 32'd0);
        chk("arst_q",    32'(exp_q.size()), 32'd0);
        push_clears();
        @(negedge CLK);
        #1;
        nrst = 1'b1;
        drain(200, n);
        chk("rst_clear_len", 32'(n), 32'd64);
        repeat (3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
